int_issue_queue: RTL and testbench
==================================

// Module: int_issue_queue
// PURPOSE
//  Receive side of the integer dispatch path. Buffers dispatched int entries (R/I/branch/JALR/LUI/AUIPC).
//  Wakes waiting operands by snooping the common data bus (CDB).
//  Issues the oldest entry whose rs1 and rs2 are both valid to the integer execution unit, with a valid/ready handshake.
//  Sits between the dispatch generator and the int ALU. Its full flag back-pressures dispatch.
// PARAMETERS
//  DEPTH     4   number of entries; power of two, >=2
//  TAG_W     6   ROB/rename tag width (rd_tag, rs1_tag, rs2_tag, cdb_tag)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  flush          in   1   sync clear of all entries (branch mispredict)
//  int_dispatch_en in  1   write dispatch entry this cycle
//  d_opcode/d_func3/d_func7 in 7/3/7  instruction decode fields
//  d_rs1_data/d_rs2_data    in 32/32  operand values (rs2 = imm for I/LUI)
//  d_rs1_tag/d_rs2_tag      in TAG_W  producer tags
//  d_rs1_valid/d_rs2_valid  in 1/1    operand already available
//  d_rd_tag       in   TAG_W  destination tag
//  d_wb_valid     in   1   result is written back (0 when rd==x0)
//  cdb_valid      in   1   CDB broadcast valid
//  cdb_tag        in   TAG_W  broadcast tag
//  cdb_data       in   32  broadcast result
//  iq_full        out  1   count==DEPTH
//  iq_count       out  $clog2(DEPTH+1)  occupied entries
//  issue_valid    out  1   issue_* fields hold a ready entry
//  issue_ready    in   1   int unit accepts this cycle
//  issue_opcode/func3/func7 out 7/3/7
//  issue_rs1_data/issue_rs2_data out 32/32
//  issue_rd_tag   out  TAG_W
//  issue_wb_valid out  1
// BEHAVIOUR
//  - Reset (async) and flush (sync): all entry valid bits 0, count 0, iq_full 0, issue_valid 0, all issue_* 0.
//  - Flush has priority over dispatch, issue and CDB in the same cycle.
//  - Storage is age-ordered and collapsing: slot 0 is the oldest. New entries go to slot count (after any removal this cycle).
//  - Dispatch: on int_dispatch_en && !iq_full the entry is written at the clock edge.
//    - Dispatch while iq_full is dropped. This holds even if an issue frees a slot in the same cycle; upstream must stall on iq_full.
//  - Wakeup: each stored operand with valid=0 and tag==cdb_tag, when cdb_valid=1, captures cdb_data and sets valid=1 at the edge.
//  - Bypass: a dispatching operand with valid=0 and tag==cdb_tag in a cdb_valid cycle is written with cdb_data and valid=1.
//  - Select: combinational from registered state. Picks the lowest-index slot with rs1_valid && rs2_valid.
//    - issue_valid=1 and issue_* = that slot's fields; otherwise issue_valid=0 and issue_* = 0.
//    - An operand woken by CDB this cycle becomes eligible next cycle (1-cycle wakeup-to-issue).
//  - Handshake: issue_valid && issue_ready removes the selected slot at the edge. Younger slots shift down by one, order kept.
//    - issue_* must stay stable while issue_valid && !issue_ready, unless an older entry becomes ready.
//  - Simultaneous issue + dispatch (not full): count unchanged; the new entry lands at slot count-1.
//  - Simultaneous CDB wakeup on a shifting slot: the wakeup applies to the shifted entry at its new index.
//  - Reset mid-operation discards all entries; no issue occurs on the reset-release edge.
// TESTING
//  - Reset then dispatch ADD, rs1/rs2 valid, rd_tag=5 -> issue_valid=1 next cycle; issue_rd_tag=5; after handshake count=0.
//  - Dispatch entry rs1_tag=9, rs1_valid=0. CDB tag=9, data=0x1234 two cycles later -> issue_valid=1 one cycle after CDB; issue_rs1_data=0x1234.
//  - Dispatch with rs2_tag=3 invalid in the same cycle as cdb_tag=3, data=0xAA -> entry stored ready; issues next cycle with rs2=0xAA.
//  - Fill 4 entries, iq_full=1, dispatch 5th with issue_ready=1 -> 5th dropped, count=3; remaining order preserved.
//  - Slot0 blocked (tag 7), slot1 ready -> slot1 issues first; then CDB tag 7 -> slot0 issues next.
//  - Flush with 3 entries plus concurrent dispatch/CDB -> count=0, issue_valid=0 the following cycle.

Source files
------------

// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered collapsing buffer with CDB wakeup
// and oldest-ready select toward the int execution unit.
module int_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       int_dispatch_en,
  input  logic [6:0]                 d_opcode,
  input  logic [2:0]                 d_func3,
  input  logic [6:0]                 d_func7,
  input  logic [31:0]                d_rs1_data,
  input  logic [31:0]                d_rs2_data,
  input  logic [TAG_W-1:0]           d_rs1_tag,
  input  logic [TAG_W-1:0]           d_rs2_tag,
  input  logic                       d_rs1_valid,
  input  logic                       d_rs2_valid,
  input  logic [TAG_W-1:0]           d_rd_tag,
  input  logic                       d_wb_valid,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_data,
  output logic                       iq_full,
  output logic [$clog2(DEPTH+1)-1:0] iq_count,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [6:0]                 issue_opcode,
  output logic [2:0]                 issue_func3,
  output logic [6:0]                 issue_func7,
  output logic [31:0]                issue_rs1_data,
  output logic [31:0]                issue_rs2_data,
  output logic [TAG_W-1:0]           issue_rd_tag,
  output logic                       issue_wb_valid
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs1_valid;
    logic             rs2_valid;
    logic [TAG_W-1:0] rd_tag;
    logic             wb_valid;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] cnt_rm;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          do_issue;
  logic          accept;
  ent_t          new_ent;

  function automatic ent_t wake(
    input ent_t             e,
    input logic             cv,
    input logic [TAG_W-1:0] ct,
    input logic [31:0]      cd
  );
    ent_t r;
    r = e;
    if (cv && !r.rs1_valid && r.rs1_tag == ct) begin
      r.rs1_data  = cd;
      r.rs1_valid = 1'b1;
    end
    if (cv && !r.rs2_valid && r.rs2_tag == ct) begin
      r.rs2_data  = cd;
      r.rs2_valid = 1'b1;
    end
    return r;
  endfunction

  // Reverse scan so the lowest (oldest) ready slot wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (i < int'(count_q) &&
          ent_q[i].rs1_valid && ent_q[i].rs2_valid) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign iq_full        = (count_q == CW'(DEPTH));
  assign iq_count       = count_q;
  assign issue_valid    = sel_found;
  assign issue_opcode   = sel_found ? ent_q[sel_idx].opcode   : '0;
  assign issue_func3    = sel_found ? ent_q[sel_idx].func3    : '0;
  assign issue_func7    = sel_found ? ent_q[sel_idx].func7    : '0;
  assign issue_rs1_data = sel_found ? ent_q[sel_idx].rs1_data : '0;
  assign issue_rs2_data = sel_found ? ent_q[sel_idx].rs2_data : '0;
  assign issue_rd_tag   = sel_found ? ent_q[sel_idx].rd_tag   : '0;
  assign issue_wb_valid = sel_found ? ent_q[sel_idx].wb_valid : 1'b0;

  assign do_issue = sel_found && issue_ready;
  assign accept   = int_dispatch_en && !iq_full;

  always_comb begin
    new_ent.opcode    = d_opcode;
    new_ent.func3     = d_func3;
    new_ent.func7     = d_func7;
    new_ent.rs1_data  = d_rs1_data;
    new_ent.rs2_data  = d_rs2_data;
    new_ent.rs1_tag   = d_rs1_tag;
    new_ent.rs2_tag   = d_rs2_tag;
    new_ent.rs1_valid = d_rs1_valid;
    new_ent.rs2_valid = d_rs2_valid;
    new_ent.rd_tag    = d_rd_tag;
    new_ent.wb_valid  = d_wb_valid;
  end

  // Collapse above the issued slot, then wake, then append.
  always_comb begin
    for (int i = 0; i < DEPTH-1; i++) begin
      if (do_issue && i >= int'(sel_idx))
        ent_d[i] = ent_q[i+1];
      else
        ent_d[i] = ent_q[i];
    end
    ent_d[DEPTH-1] = do_issue ? '0 : ent_q[DEPTH-1];
    for (int i = 0; i < DEPTH; i++)
      ent_d[i] = wake(ent_d[i], cdb_valid, cdb_tag, cdb_data);
    cnt_rm = count_q - CW'(do_issue);
    if (accept)
      ent_d[IW'(cnt_rm)] = wake(new_ent, cdb_valid, cdb_tag, cdb_data);
    count_d = cnt_rm + CW'(accept);
    if (flush) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++)
        ent_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_int_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             int_dispatch_en;
  logic [6:0]       d_opcode;
  logic [2:0]       d_func3;
  logic [6:0]       d_func7;
  logic [31:0]      d_rs1_data;
  logic [31:0]      d_rs2_data;
  logic [TAG_W-1:0] d_rs1_tag;
  logic [TAG_W-1:0] d_rs2_tag;
  logic             d_rs1_valid;
  logic             d_rs2_valid;
  logic [TAG_W-1:0] d_rd_tag;
  logic             d_wb_valid;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             iq_full;
  logic [2:0]       iq_count;
  logic             issue_valid;
  logic             issue_ready;
  logic [6:0]       issue_opcode;
  logic [2:0]       issue_func3;
  logic [6:0]       issue_func7;
  logic [31:0]      issue_rs1_data;
  logic [31:0]      issue_rs2_data;
  logic [TAG_W-1:0] issue_rd_tag;
  logic             issue_wb_valid;

  int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .int_dispatch_en(int_dispatch_en),
    .d_opcode(d_opcode), .d_func3(d_func3), .d_func7(d_func7),
    .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data),
    .d_rs1_tag(d_rs1_tag), .d_rs2_tag(d_rs2_tag),
    .d_rs1_valid(d_rs1_valid), .d_rs2_valid(d_rs2_valid),
    .d_rd_tag(d_rd_tag), .d_wb_valid(d_wb_valid),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iq_full(iq_full), .iq_count(iq_count),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_func3(issue_func3),
    .issue_func7(issue_func7),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rd_tag(issue_rd_tag), .issue_wb_valid(issue_wb_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit [6:0]  op;
    bit [2:0]  f3;
    bit [6:0]  f7;
    bit [31:0] a;
    bit [31:0] b;
    bit [5:0]  ta;
    bit [5:0]  tb;
    bit        va;
    bit        vb;
    bit [5:0]  rd;
    bit        wb;
  } mentry_t;

  mentry_t mq[$];

  typedef struct {
    bit fl, en, va;
    bit [5:0] ta;
    bit [31:0] a;
    bit vb;
    bit [5:0] tb;
    bit [31:0] b;
    bit [5:0] rd;
    bit cv;
    bit [5:0] ct;
    bit [31:0] cd;
    bit rdy;
    int cnt;
    bit full, iv;
    bit [5:0] erd;
    bit [31:0] ea, eb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; int_dispatch_en = 0;
    d_opcode = 7'h33; d_func3 = 0; d_func7 = 0;
    d_rs1_data = 0; d_rs2_data = 0; d_rs1_tag = 0; d_rs2_tag = 0;
    d_rs1_valid = 0; d_rs2_valid = 0; d_rd_tag = 0; d_wb_valid = 1;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; issue_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    bit fl, bit en, bit va, bit [5:0] ta, bit [31:0] a,
    bit vb, bit [5:0] tb, bit [31:0] b, bit [5:0] rd,
    bit cv, bit [5:0] ct, bit [31:0] cd, bit rdy,
    int cnt, bit full, bit iv, bit [5:0] erd,
    bit [31:0] ea, bit [31:0] eb);
    vec_t v;
    v.fl = fl; v.en = en; v.va = va; v.ta = ta; v.a = a;
    v.vb = vb; v.tb = tb; v.b = b; v.rd = rd;
    v.cv = cv; v.ct = ct; v.cd = cd; v.rdy = rdy;
    v.cnt = cnt; v.full = full; v.iv = iv; v.erd = erd;
    v.ea = ea; v.eb = eb;
    return v;
  endfunction

  function automatic int model_sel();
    foreach (mq[j]) if (mq[j].va && mq[j].vb) return j;
    return -1;
  endfunction

  function automatic logic [127:0] model_out();
    int s;
    mentry_t e;
    s = model_sel();
    e = '{default: 0};
    if (s >= 0) e = mq[s];
    return {35'b0, e.op, e.f3, e.f7, e.a, e.b, e.rd, e.wb,
            s >= 0, 3'(mq.size()), mq.size() == DEPTH};
  endfunction

  function automatic logic [127:0] dut_out();
    return {35'b0, issue_opcode, issue_func3, issue_func7,
            issue_rs1_data, issue_rs2_data, issue_rd_tag,
            issue_wb_valid, issue_valid, iq_count, iq_full};
  endfunction

  function automatic mentry_t mwake(mentry_t e, bit cv,
                                    bit [5:0] ct, bit [31:0] cd);
    mentry_t r = e;
    if (cv && !r.va && r.ta == ct) begin r.a = cd; r.va = 1; end
    if (cv && !r.vb && r.tb == ct) begin r.b = cd; r.vb = 1; end
    return r;
  endfunction

  initial begin
    idle();
    rst = 1;
    #12;
    chk("reset.count", iq_count, 0);
    chk("reset.valid", {issue_valid, iq_full, issue_rd_tag}, 0);
    rst = 0;
    tick();

    // fl en va ta a vb tb b rd cv ct cd rdy | cnt full iv erd ea eb
    tbl.push_back(mk(0,1,1,0,11,1,0,22,5, 0,0,0,0, 1,0,1,5,11,22));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,9,32'hDEAD,1,0,32'h77,6, 0,0,0,1,
                     1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,9,32'h1234,1,
                     1,0,1,6,32'h1234,32'h77));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,0,3,32'hBEEF,7, 1,3,32'hAA,0,
                     1,0,1,7,1,32'hAA));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0));
    for (int r = 0; r < 4; r++)
      tbl.push_back(mk(0,1,1,0,10+r,1,0,0,6'(10+r), 0,0,0,0,
                       r+1,r==3,1,10,10,0));
    tbl.push_back(mk(0,1,1,0,14,1,0,0,14, 0,0,0,1, 3,0,1,11,11,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1, 2,0,1,12,12,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1, 1,0,1,13,13,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0));
    for (int r = 0; r < 3; r++)
      tbl.push_back(mk(0,1,1,0,20+r,1,0,1,6'(20+r), 0,0,0,0,
                       r+1,0,1,20,20,1));
    tbl.push_back(mk(1,1,0,5,0,1,0,0,23, 1,5,32'h55,1,
                     0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));

    foreach (tbl[k]) begin
      flush = tbl[k].fl; int_dispatch_en = tbl[k].en;
      d_rs1_valid = tbl[k].va; d_rs1_tag = tbl[k].ta;
      d_rs1_data = tbl[k].a; d_rs2_valid = tbl[k].vb;
      d_rs2_tag = tbl[k].tb; d_rs2_data = tbl[k].b;
      d_rd_tag = tbl[k].rd; cdb_valid = tbl[k].cv;
      cdb_tag = tbl[k].ct; cdb_data = tbl[k].cd;
      issue_ready = tbl[k].rdy;
      tick();
      chk($sformatf("vec%0d.count", k), iq_count, tbl[k].cnt);
      chk($sformatf("vec%0d.full", k), iq_full, tbl[k].full);
      chk($sformatf("vec%0d.ivalid", k), issue_valid, tbl[k].iv);
      chk($sformatf("vec%0d.rd", k), issue_rd_tag, tbl[k].erd);
      chk($sformatf("vec%0d.rs1", k), issue_rs1_data, tbl[k].ea);
      chk($sformatf("vec%0d.rs2", k), issue_rs2_data, tbl[k].eb);
    end

    // Oldest blocked on tag 7, younger ready entry bypasses it.
    idle();
    int_dispatch_en = 1; d_rd_tag = 30;
    d_rs1_valid = 0; d_rs1_tag = 7; d_rs2_valid = 1; d_rs2_data = 5;
    tick();
    d_rd_tag = 31; d_rs1_valid = 1; d_rs1_data = 3;
    tick();
    idle();
    chk("blk.first", {iq_count, issue_valid, issue_rd_tag},
        {3'd2, 1'b1, 6'd31});
    issue_ready = 1;
    tick();
    chk("blk.after", {iq_count, issue_valid}, {3'd1, 1'b0});
    cdb_valid = 1; cdb_tag = 7; cdb_data = 32'h700;
    tick();
    cdb_valid = 0;
    chk("blk.woken", {issue_valid, issue_rd_tag, issue_rs1_data},
        {1'b1, 6'd30, 32'h700});
    tick();
    chk("blk.drain", {iq_count, issue_valid}, {3'd0, 1'b0});

    // Async reset in the middle of a cycle with live entries.
    idle();
    int_dispatch_en = 1; d_rs1_valid = 1; d_rs2_valid = 1; d_rd_tag = 40;
    tick();
    tick();
    idle();
    issue_ready = 1;
    #2;
    rst = 1;
    #1;
    chk("midrst.async", {iq_count, issue_valid}, {3'd0, 1'b0});
    tick();
    rst = 0;
    tick();
    chk("midrst.release", {iq_count, issue_valid, issue_rd_tag}, 0);

    // Random traffic vs. queue model (both empty here).
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      mentry_t ne;
      int s;
      bit was_full;
      flush = ($urandom_range(0, 63) == 0);
      int_dispatch_en = ($urandom_range(0, 99) < 60);
      d_opcode = 7'($urandom); d_func3 = 3'($urandom);
      d_func7 = 7'($urandom);
      d_rs1_data = $urandom; d_rs2_data = $urandom;
      d_rs1_tag = 6'($urandom_range(0, 7));
      d_rs2_tag = 6'($urandom_range(0, 7));
      d_rs1_valid = $urandom_range(0, 1);
      d_rs2_valid = $urandom_range(0, 1);
      d_rd_tag = 6'($urandom); d_wb_valid = $urandom_range(0, 1);
      cdb_valid = ($urandom_range(0, 99) < 40);
      cdb_tag = 6'($urandom_range(0, 7)); cdb_data = $urandom;
      issue_ready = ($urandom_range(0, 99) < 45);
      #1;
      chk($sformatf("rnd%0d.pre", c), dut_out(), model_out());
      if (flush) begin
        mq.delete();
      end else begin
        was_full = (mq.size() == DEPTH);
        s = model_sel();
        if (s >= 0 && issue_ready) mq.delete(s);
        foreach (mq[j]) mq[j] = mwake(mq[j], cdb_valid, cdb_tag, cdb_data);
        if (int_dispatch_en && !was_full) begin
          ne.op = d_opcode; ne.f3 = d_func3; ne.f7 = d_func7;
          ne.a = d_rs1_data; ne.b = d_rs2_data;
          ne.ta = d_rs1_tag; ne.tb = d_rs2_tag;
          ne.va = d_rs1_valid; ne.vb = d_rs2_valid;
          ne.rd = d_rd_tag; ne.wb = d_wb_valid;
          mq.push_back(mwake(ne, cdb_valid, cdb_tag, cdb_data));
        end
      end
      tick();
    end
    idle();
    #1;
    chk("rnd.final", dut_out(), model_out());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
